// File: rtl/uart_regfile_fifo_if.sv
// Host register bus plus TX FIFO drain handshake for uart_regfile_fifo.
// master = host/transmitter side, slave = register file.
interface uart_regfile_fifo_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       addr;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;

  modport master (
    output addr, wr_en, wr_data, tx_ready,
    input  rd_data, tx_data, tx_valid
  );

  modport slave (
    input  addr, wr_en, wr_data, tx_ready,
    output rd_data, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_regfile_fifo.sv
// UART host register file: DATA (TX FIFO), STATUS (W1C sticky bits), CONTROL, BRD, maskable IRQ.
// Define UART_RF_RDREG_EN to register the read data path (1-cycle read latency).
module uart_regfile_fifo #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int BRD_RST = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_regfile_fifo_if.slave bus,
  input  logic               err_set,
  output logic [WIDTH-1:0]   ctrl_out,
  output logic [WIDTH-1:0]   brd_out,
  output logic               irq
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0]   cnt_t;
  typedef logic [AW-1:0] ptr_t;

  localparam cnt_t       CNT_FULL = cnt_t'(DEPTH);
  localparam cnt_t       CNT_ONE  = cnt_t'(1);
  localparam ptr_t       PTR_ONE  = ptr_t'(1);
  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_BRD    = 2'd3;

  if (WIDTH < 4) begin : g_width_chk
    $error("uart_regfile_fifo: WIDTH must be >= 4");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("uart_regfile_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] fifo_mem [DEPTH];
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  cnt_t             count;
  logic             ovf;
  logic             err;
  logic [WIDTH-1:0] ctrl_reg;
  logic [WIDTH-1:0] brd_reg;

  logic             full;
  logic             empty;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             ovf_set;
  logic             sts_wr;
  logic [WIDTH-1:0] status_val;
  logic [WIDTH-1:0] rd_mux;

  function automatic logic [WIDTH-1:0] rd_select(
    input logic [1:0]       sel,
    input cnt_t             cnt,
    input logic [WIDTH-1:0] status,
    input logic [WIDTH-1:0] ctrl,
    input logic [WIDTH-1:0] brd
  );
    logic [WIDTH-1:0] res;
    res = '0;
    case (sel)
      A_DATA:   res = WIDTH'(cnt);
      A_STATUS: res = status;
      A_CTRL:   res = ctrl;
      default:  res = brd;
    endcase
    return res;
  endfunction

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign push_req = bus.wr_en && (bus.addr == A_DATA);
  // A full FIFO rejects the push even if a pop frees a slot this cycle.
  assign push     = push_req && !full;
  assign ovf_set  = push_req && full;
  assign pop      = !empty && bus.tx_ready;
  assign sts_wr   = bus.wr_en && (bus.addr == A_STATUS);

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.wr_data;
  end

  // Sticky status bits (hardware set beats W1C) and host registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf      <= 1'b0;
      err      <= 1'b0;
      ctrl_reg <= '0;
      brd_reg  <= WIDTH'(BRD_RST);
    end else begin
      if (ovf_set)                     ovf <= 1'b1;
      else if (sts_wr && bus.wr_data[2]) ovf <= 1'b0;

      if (err_set)                     err <= 1'b1;
      else if (sts_wr && bus.wr_data[3]) err <= 1'b0;

      if (bus.wr_en && (bus.addr == A_CTRL)) ctrl_reg <= bus.wr_data;
      if (bus.wr_en && (bus.addr == A_BRD))  brd_reg  <= bus.wr_data;
    end
  end

  always_comb begin
    status_val      = '0;
    status_val[3:0] = {err, ovf, empty, full};
  end

  always_comb begin
    rd_mux = rd_select(bus.addr, count, status_val, ctrl_reg, brd_reg);
  end

`ifdef UART_RF_RDREG_EN
  logic [WIDTH-1:0] rd_data_p1;

  // Read stage: ADDR and state captured at the edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_p1 <= '0;
    else        rd_data_p1 <= rd_mux;
  end

  assign bus.rd_data = rd_data_p1;
`else
  assign bus.rd_data = rd_mux;
`endif

  assign bus.tx_data  = fifo_mem[rd_ptr];
  assign bus.tx_valid = !empty;
  assign ctrl_out     = ctrl_reg;
  assign brd_out      = brd_reg;
  assign irq          = (ovf & ctrl_reg[0]) | (err & ctrl_reg[1]);

endmodule

// File: tb/tb_uart_regfile_fifo.sv
// Randomised self-checking bench for uart_regfile_fifo against a queue-based reference model.
module tb_uart_regfile_fifo;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int BRD_RST = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic err_set;
  logic [WIDTH-1:0] ctrl_out, brd_out;
  logic irq;

  uart_regfile_fifo_if #(.WIDTH(WIDTH)) bus ();

  uart_regfile_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BRD_RST(BRD_RST)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .err_set  (err_set),
    .ctrl_out (ctrl_out),
    .brd_out  (brd_out),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Reference model
  logic [7:0] m_q[$];
  bit         m_ovf, m_err;
  logic [7:0] m_ctrl, m_brd;

  function automatic void model_reset();
    m_q.delete();
    m_ovf  = 1'b0;
    m_err  = 1'b0;
    m_ctrl = 8'h00;
    m_brd  = 8'(BRD_RST);
  endfunction

  function automatic logic [7:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return 8'(m_q.size());
      2'd1:    return {4'b0, m_err, m_ovf, m_q.size() == 0, m_q.size() == DEPTH};
      2'd2:    return m_ctrl;
      default: return m_brd;
    endcase
  endfunction

  function automatic logic exp_irq();
    return (m_ovf & m_ctrl[0]) | (m_err & m_ctrl[1]);
  endfunction

  // One clock: capture driven inputs, advance model at the edge, return at negedge.
  task automatic cycle();
    logic [1:0] a;
    logic we, tr, es, full, popped, pushed;
    logic [7:0] d;
    a = bus.addr; we = bus.wr_en; d = bus.wr_data; tr = bus.tx_ready; es = err_set;
    @(posedge clk);
    full   = (m_q.size() == DEPTH);
    popped = (m_q.size() != 0) && tr;
    pushed = we && (a == 2'd0) && !full;
    if (popped) void'(m_q.pop_front());
    if (pushed) m_q.push_back(d);
    if (we && a == 2'd0 && full)      m_ovf = 1'b1;
    else if (we && a == 2'd1 && d[2]) m_ovf = 1'b0;
    if (es)                           m_err = 1'b1;
    else if (we && a == 2'd1 && d[3]) m_err = 1'b0;
    if (we && a == 2'd2) m_ctrl = d;
    if (we && a == 2'd3) m_brd  = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
    err_set   = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.addr = a; bus.wr_en = 1'b1; bus.wr_data = d;
    cycle();
  endtask

  task automatic do_read(input logic [1:0] a);
    bus.addr = a; bus.wr_en = 1'b0;
`ifdef UART_RF_RDREG_EN
    cycle();
`else
    #1;
`endif
  endtask

  task automatic test_reset();
    logic [7:0] e;
    repeat (2) @(negedge clk);
    chk_cnt++; if (ctrl_out !== 8'h00) $display("FAIL rst_ctrl: got %h exp 00", ctrl_out); else pass_cnt++;
    chk_cnt++; if (brd_out !== 8'h10) $display("FAIL rst_brd: got %h exp 10", brd_out); else pass_cnt++;
    chk_cnt++; if (bus.tx_valid !== 1'b0) $display("FAIL rst_txvalid: got %b exp 0", bus.tx_valid); else pass_cnt++;
    chk_cnt++; if (irq !== 1'b0) $display("FAIL rst_irq: got %b exp 0", irq); else pass_cnt++;
    bus.addr = 2'd1; #1;
`ifdef UART_RF_RDREG_EN
    e = 8'h00;
`else
    e = 8'h02;
`endif
    chk_cnt++; if (bus.rd_data !== e) $display("FAIL rst_rd: got %h exp %h", bus.rd_data, e); else pass_cnt++;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    do_read(2'd1);
    chk_cnt++; if (bus.rd_data !== 8'h02) $display("FAIL rst_status: got %h exp 02", bus.rd_data); else pass_cnt++;
  endtask

  task automatic test_regs();
    logic [7:0] e;
    wr(2'd3, 8'hA5);
    chk_cnt++; if (brd_out !== 8'hA5) $display("FAIL brd_out: got %h exp a5", brd_out); else pass_cnt++;
    wr(2'd2, 8'h03);
    chk_cnt++; if (ctrl_out !== 8'h03) $display("FAIL ctrl_out: got %h exp 03", ctrl_out); else pass_cnt++;
    e = exp_rd(2'd3); do_read(2'd3);
    chk_cnt++; if (bus.rd_data !== 8'hA5) $display("FAIL brd_rd: got %h exp a5 (model %h)", bus.rd_data, e); else pass_cnt++;
    do_read(2'd2);
    chk_cnt++; if (bus.rd_data !== 8'h03) $display("FAIL ctrl_rd: got %h exp 03", bus.rd_data); else pass_cnt++;
    wr(2'd1, 8'h03);
    do_read(2'd1);
    chk_cnt++; if (bus.rd_data !== 8'h02) $display("FAIL sts_ro: got %h exp 02", bus.rd_data); else pass_cnt++;
    chk_cnt++; if (irq !== 1'b0) $display("FAIL regs_irq: got %b exp 0", irq); else pass_cnt++;
  endtask

  task automatic test_fill_overflow();
    logic [7:0] vals [5];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(2'd0, vals[i]);
    do_read(2'd1);
    chk_cnt++; if (bus.rd_data !== 8'h05) $display("FAIL ovf_status: got %h exp 05", bus.rd_data); else pass_cnt++;
    do_read(2'd0);
    chk_cnt++; if (bus.rd_data !== 8'h04) $display("FAIL ovf_count: got %h exp 04", bus.rd_data); else pass_cnt++;
    chk_cnt++; if (irq !== 1'b1) $display("FAIL ovf_irq: got %b exp 1", irq); else pass_cnt++;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== vals[i])
        $display("FAIL drain_%0d: got v=%b d=%h exp v=1 d=%h", i, bus.tx_valid, bus.tx_data, vals[i]);
      else pass_cnt++;
      cycle();
    end
    chk_cnt++; if (bus.tx_valid !== 1'b0) $display("FAIL drain_empty: got %b exp 0", bus.tx_valid); else pass_cnt++;
    do_read(2'd1);
    chk_cnt++; if (bus.rd_data !== 8'h06) $display("FAIL drain_status: got %h exp 06", bus.rd_data); else pass_cnt++;
    bus.tx_ready = 1'b0;
    wr(2'd1, 8'h04);
    wr(2'd2, 8'h00);
    do_read(2'd1);
    chk_cnt++; if (bus.rd_data !== 8'h02) $display("FAIL ovf_clear: got %h exp 02", bus.rd_data); else pass_cnt++;
  endtask

  task automatic test_push_pop_same();
    logic [7:0] a_v, b_v;
    a_v = 8'($urandom); b_v = 8'($urandom);
    bus.tx_ready = 1'b0;
    wr(2'd0, a_v);
    wr(2'd0, b_v);
    bus.tx_ready = 1'b1;
    wr(2'd0, 8'h66);
    bus.tx_ready = 1'b0;
    do_read(2'd0);
    chk_cnt++; if (bus.rd_data !== 8'h02) $display("FAIL pp_count: got %h exp 02", bus.rd_data); else pass_cnt++;
    chk_cnt++; if (bus.tx_data !== b_v) $display("FAIL pp_head: got %h exp %h", bus.tx_data, b_v); else pass_cnt++;
    bus.tx_ready = 1'b1;
    cycle();
    chk_cnt++; if (bus.tx_data !== 8'h66 || bus.tx_valid !== 1'b1) $display("FAIL pp_last: got %h exp 66", bus.tx_data); else pass_cnt++;
    cycle();
    chk_cnt++; if (bus.tx_valid !== 1'b0) $display("FAIL pp_empty: got %b exp 0", bus.tx_valid); else pass_cnt++;
    for (int r = 0; r < 10; r++) begin
      wr(2'd0, 8'($urandom));
      chk_cnt++;
      if (bus.tx_valid !== (m_q.size() != 0) || (m_q.size() != 0 && bus.tx_data !== m_q[0]))
        $display("FAIL wrap_%0d: got v=%b d=%h exp d=%h", r, bus.tx_valid, bus.tx_data, m_q.size() != 0 ? m_q[0] : 8'h00);
      else pass_cnt++;
    end
    for (int i = 0; i < 2 * DEPTH; i++) cycle();
    chk_cnt++; if (bus.tx_valid !== 1'b0) $display("FAIL wrap_drain: got %b exp 0", bus.tx_valid); else pass_cnt++;
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_err_irq();
    wr(2'd2, 8'h02);
    err_set = 1'b1;
    cycle();
    chk_cnt++; if (irq !== 1'b1) $display("FAIL err_irq: got %b exp 1", irq); else pass_cnt++;
    do_read(2'd1);
    chk_cnt++; if (bus.rd_data[3] !== 1'b1) $display("FAIL err_bit: got %h exp bit3=1", bus.rd_data); else pass_cnt++;
    err_set = 1'b1;
    wr(2'd1, 8'h08);
    do_read(2'd1);
    chk_cnt++; if (bus.rd_data !== 8'h0A) $display("FAIL err_setwins: got %h exp 0a", bus.rd_data); else pass_cnt++;
    chk_cnt++; if (irq !== 1'b1) $display("FAIL err_setwins_irq: got %b exp 1", irq); else pass_cnt++;
    wr(2'd1, 8'h08);
    chk_cnt++; if (irq !== 1'b0) $display("FAIL err_clr_irq: got %b exp 0", irq); else pass_cnt++;
    do_read(2'd1);
    chk_cnt++; if (bus.rd_data !== 8'h02) $display("FAIL err_clr: got %h exp 02", bus.rd_data); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0] e;
    for (int n = 0; n < 300; n++) begin
      bus.addr     = 2'($urandom);
      bus.wr_en    = ($urandom_range(0, 1) == 1);
      bus.wr_data  = 8'($urandom);
      bus.tx_ready = ($urandom_range(0, 2) == 0);
      err_set      = ($urandom_range(0, 7) == 0);
`ifdef UART_RF_RDREG_EN
      e = exp_rd(bus.addr);
      cycle();
`else
      #1;
      e = exp_rd(bus.addr);
      chk_cnt++; if (bus.rd_data !== e) $display("FAIL rnd_rd_%0d: got %h exp %h", n, bus.rd_data, e); else pass_cnt++;
      cycle();
      e = exp_rd(bus.addr);
`endif
      chk_cnt++; if (bus.rd_data !== e) $display("FAIL rnd_rdq_%0d: got %h exp %h", n, bus.rd_data, e); else pass_cnt++;
      chk_cnt++;
      if (bus.tx_valid !== (m_q.size() != 0) || (m_q.size() != 0 && bus.tx_data !== m_q[0]))
        $display("FAIL rnd_tx_%0d: got v=%b d=%h exp n=%0d", n, bus.tx_valid, bus.tx_data, m_q.size());
      else pass_cnt++;
      chk_cnt++; if (irq !== exp_irq()) $display("FAIL rnd_irq_%0d: got %b exp %b", n, irq, exp_irq()); else pass_cnt++;
      chk_cnt++;
      if (ctrl_out !== m_ctrl || brd_out !== m_brd)
        $display("FAIL rnd_regs_%0d: got %h/%h exp %h/%h", n, ctrl_out, brd_out, m_ctrl, m_brd);
      else pass_cnt++;
    end
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    wr(2'd3, 8'h5A);
    wr(2'd1, 8'h0C);
    for (int i = 0; i < 3; i++) wr(2'd0, 8'($urandom));
    bus.addr = 2'd0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk_cnt++; if (bus.tx_valid !== 1'b0) $display("FAIL mid_txvalid: got %b exp 0", bus.tx_valid); else pass_cnt++;
    chk_cnt++; if (bus.rd_data !== 8'h00) $display("FAIL mid_count: got %h exp 00", bus.rd_data); else pass_cnt++;
    chk_cnt++; if (brd_out !== 8'h10) $display("FAIL mid_brd: got %h exp 10", brd_out); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    bus.addr = 2'd3; #1;
`ifdef UART_RF_RDREG_EN
    chk_cnt++; if (bus.rd_data !== 8'h00) $display("FAIL lag_before: got %h exp 00", bus.rd_data); else pass_cnt++;
    cycle();
    chk_cnt++; if (bus.rd_data !== 8'h10) $display("FAIL lag_after: got %h exp 10", bus.rd_data); else pass_cnt++;
    bus.addr = 2'd1; #1;
    chk_cnt++; if (bus.rd_data !== 8'h10) $display("FAIL lag_hold: got %h exp 10", bus.rd_data); else pass_cnt++;
    cycle();
    chk_cnt++; if (bus.rd_data !== 8'h02) $display("FAIL lag_status: got %h exp 02", bus.rd_data); else pass_cnt++;
`else
    chk_cnt++; if (bus.rd_data !== 8'h10) $display("FAIL comb_brd: got %h exp 10", bus.rd_data); else pass_cnt++;
    bus.addr = 2'd1; #1;
    chk_cnt++; if (bus.rd_data !== 8'h02) $display("FAIL comb_status: got %h exp 02", bus.rd_data); else pass_cnt++;
    cycle();
`endif
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.addr     = 2'd0;
    bus.wr_en    = 1'b0;
    bus.wr_data  = '0;
    bus.tx_ready = 1'b0;
    err_set      = 1'b0;
    model_reset();
    test_reset();
    test_regs();
    test_fill_overflow();
    test_push_pop_same();
    test_err_irq();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
